// File: rtl/fb_wr_arbiter.sv
// Round-robin write-port arbiter for the frame/line RAM, with an optional
// full-RAM clear engine built only when FB_WR_ARBITER_CLEAR_EN is defined.
module fb_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_N     = 16,
  parameter int ADDR_BITS  = $clog2(DATA_N),
  parameter int NUM_REQ    = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*ADDR_BITS-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic                            clr_start,
  input  logic [DATA_WIDTH-1:0]           clr_val,
  output logic                            clr_busy,
  output logic                            clr_done,
  output logic                            dbg_clr_state,
  output logic                            wr_en,
  output logic [ADDR_BITS-1:0]            wr_addr,
  output logic [DATA_WIDTH-1:0]           wr_in
);

  // Handshake: requester i transfers on a rising clk edge where
  // req_valid[i] & req_ready[i]; ready is combinational and data-independent.
  localparam int LG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [LG_W-1:0]       last_grant_q, last_grant_d;
  logic [LG_W-1:0]       gnt_idx, idx_hi, idx_lo;
  logic                  found_hi, found_lo;
  logic                  grant_block, xfer;
  logic [ADDR_BITS-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  clr_wr;
  logic [ADDR_BITS-1:0]  clr_addr;
  logic [DATA_WIDTH-1:0] clr_data;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_in_q, wr_in_d;

  // Lowest valid index above last_grant wins; otherwise lowest index at or below it.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (i > int'(last_grant_q)) begin
          found_hi = 1'b1;
          idx_hi   = LG_W'(i);
        end else begin
          found_lo = 1'b1;
          idx_lo   = LG_W'(i);
        end
      end
    end
    gnt_idx = found_hi ? idx_hi : idx_lo;
  end

  assign xfer = (found_hi | found_lo) & ~grant_block;

  always_comb begin
    req_ready = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = xfer && (gnt_idx == LG_W'(i));
      if (gnt_idx == LG_W'(i)) begin
        sel_addr = req_addr[i*ADDR_BITS +: ADDR_BITS];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef FB_WR_ARBITER_CLEAR_EN
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_CLEAR = 1'b1;

  logic                  state_q, state_d;
  logic [ADDR_BITS:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] val_q, val_d;
  logic                  done_q, done_d;
  logic                  clr_last;

  assign clr_last = (cnt_q == (ADDR_BITS+1)'(DATA_N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          val_d   = clr_val;
        end
      end
      default: begin
        cnt_d = cnt_q + (ADDR_BITS+1)'(1);
        if (clr_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      val_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      done_q  <= done_d;
    end
  end

  // A start pulse blocks grants in its own cycle so the clear always wins.
  assign clr_busy      = (state_q == ST_CLEAR);
  assign clr_done      = done_q;
  assign dbg_clr_state = state_q;
  assign grant_block   = clr_busy | clr_start;
  assign clr_wr        = clr_busy;
  assign clr_addr      = cnt_q[ADDR_BITS-1:0];
  assign clr_data      = val_q;
`else
  logic unused_clr;
  assign unused_clr    = ^{clr_start, clr_val};
  assign clr_busy      = 1'b0;
  assign clr_done      = 1'b0;
  assign dbg_clr_state = 1'b0;
  assign grant_block   = 1'b0;
  assign clr_wr        = 1'b0;
  assign clr_addr      = '0;
  assign clr_data      = '0;
`endif

  always_comb begin
    wr_en_d      = clr_wr | xfer;
    wr_addr_d    = wr_addr_q;
    wr_in_d      = wr_in_q;
    last_grant_d = last_grant_q;
    if (clr_wr) begin
      wr_addr_d = clr_addr;
      wr_in_d   = clr_data;
    end else if (xfer) begin
      wr_addr_d    = sel_addr;
      wr_in_d      = sel_data;
      last_grant_d = gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_in_q      <= '0;
      last_grant_q <= LG_W'(NUM_REQ - 1);
    end else begin
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_in_q      <= wr_in_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_in   = wr_in_q;

endmodule
